// File: rtl/zmips_wb_arbiter.sv
// zmips_wb_arbiter: round-robin writeback arbiter for the register file write port,
// with a per-register busy scoreboard that stalls reads of pending destinations.
module zmips_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int NREG   = 30
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    input  logic [4:0]        a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [4:0]        b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    input  logic              iss_valid,
    input  logic [4:0]        iss_addr,
    input  logic [4:0]        chk_addr_0,
    input  logic [4:0]        chk_addr_1,
    output logic              stall,
    output logic              wr,
    output logic [4:0]        wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [NREG-1:0]   busy,
    output logic              err
);
    logic              prio;
    logic              acc;
    logic              sel_ok;
    logic [4:0]        sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic [NREG-1:0]   busy_nxt;

    assign a_ready  = a_valid & (~b_valid | ~prio);
    assign b_ready  = b_valid & (~a_valid | prio);
    assign acc      = a_ready | b_ready;
    assign sel_addr = b_ready ? b_addr : a_addr;
    assign sel_data = b_ready ? b_data : a_data;
    assign sel_ok   = sel_addr < 5'(NREG);

    // a fresh issue to the register being written back wins over the clear
    always_comb begin
        busy_nxt = '0;
        stall    = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            busy_nxt[r] = (iss_valid && iss_addr == 5'(r)) | (busy[r] & ~(wr && wr_addr == 5'(r)));
            stall       = stall | (busy[r] & (chk_addr_0 == 5'(r) || chk_addr_1 == 5'(r)));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio    <= 1'b0;
            wr      <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            busy    <= '0;
            err     <= 1'b0;
        end else begin
            busy <= busy_nxt;
            wr   <= acc & sel_ok;
            err  <= err | (acc & ~sel_ok);
            if (acc) prio <= a_ready;
            if (acc && sel_ok) begin
                wr_addr <= sel_addr;
                wr_data <= sel_data;
            end
        end
    end
endmodule

// File: tb/tb_zmips_wb_arbiter.sv
// tb_zmips_wb_arbiter: vector table plus write scoreboard for the writeback arbiter.
module tb_zmips_wb_arbiter;
    logic        clk, rst;
    logic        a_valid, b_valid, iss_valid;
    logic [4:0]  a_addr, b_addr, iss_addr, chk_addr_0, chk_addr_1;
    logic [31:0] a_data, b_data;
    logic        a_ready, b_ready, stall, wr, err;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [29:0] busy;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        bv;
        logic [4:0]  ba;
        logic [31:0] bd;
        logic        iv;
        logic [4:0]  ia;
        logic [4:0]  c0;
        logic [4:0]  c1;
        logic        ear;
        logic        ebr;
        logic        est;
    } vec_t;

    typedef struct {
        logic        w;
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    vec_t vecs[$];
    wr_t  sb[$];

    zmips_wb_arbiter #(.DATA_W(32), .NREG(30)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .iss_valid(iss_valid), .iss_addr(iss_addr),
        .chk_addr_0(chk_addr_0), .chk_addr_1(chk_addr_1), .stall(stall),
        .wr(wr), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .err(err)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string n, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                                input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                                input logic iv, input logic [4:0] ia,
                                input logic [4:0] c0, input logic [4:0] c1,
                                input logic ear, input logic ebr, input logic est);
        vec_t t;
        t.av = av; t.aa = aa; t.ad = ad; t.bv = bv; t.ba = ba; t.bd = bd;
        t.iv = iv; t.ia = ia; t.c0 = c0; t.c1 = c1;
        t.ear = ear; t.ebr = ebr; t.est = est;
        return t;
    endfunction

    function automatic vec_t idle(input logic [4:0] c0, input logic [4:0] c1, input logic est);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, c0, c1, 0, 0, est);
    endfunction

    task automatic step(input vec_t t);
        wr_t e;
        a_valid = t.av; a_addr = t.aa; a_data = t.ad;
        b_valid = t.bv; b_addr = t.ba; b_data = t.bd;
        iss_valid = t.iv; iss_addr = t.ia;
        chk_addr_0 = t.c0; chk_addr_1 = t.c1;
        #1;
        check("a_ready", a_ready, t.ear);
        check("b_ready", b_ready, t.ebr);
        check("stall", stall, t.est);
        e.a = t.ear ? t.aa : t.ba;
        e.d = t.ear ? t.ad : t.bd;
        e.w = (t.ear | t.ebr) && e.a < 5'd30;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("wr", wr, e.w);
        if (e.w) begin
            check("wr_addr", wr_addr, e.a);
            check("wr_data", wr_data, e.d);
        end
    endtask

    initial begin
        rst = 1;
        a_valid = 0; b_valid = 0; iss_valid = 0;
        a_addr = 0; b_addr = 0; iss_addr = 0; a_data = 0; b_data = 0;
        chk_addr_0 = 0; chk_addr_1 = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        check("reset wr", wr, 0);
        check("reset wr_addr", wr_addr, 0);
        check("reset wr_data", wr_data, 0);
        check("reset busy", busy, 0);
        check("reset err", err, 0);

        vecs.push_back(mk(1, 5, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(idle(0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 3, 32'hB3, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 1, 32'hA1, 1, 2, 32'hB2, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 1, 32'hA1, 1, 2, 32'hB2, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 1, 32'hA1, 1, 2, 32'hB2, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 1, 32'hA1, 1, 2, 32'hB2, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(idle(0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 7, 7, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 7, 32'h77, 0, 0, 7, 0, 0, 1, 1));
        vecs.push_back(idle(7, 0, 1));
        vecs.push_back(idle(7, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 9, 9, 0, 0, 0, 0));
        vecs.push_back(mk(1, 9, 32'h99, 0, 0, 0, 0, 0, 9, 0, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 9, 9, 0, 0, 0, 1));
        vecs.push_back(idle(9, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 9, 32'h999, 0, 0, 9, 0, 0, 1, 1));
        vecs.push_back(idle(9, 0, 1));
        vecs.push_back(idle(9, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 4, 0, 4, 0, 0, 0));
        vecs.push_back(idle(31, 4, 1));
        vecs.push_back(idle(5, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 30, 30, 31, 0, 0, 0));
        vecs.push_back(idle(30, 31, 0));
        foreach (vecs[i]) step(vecs[i]);
        check("busy after table", busy, 30'h10);
        check("err before bad addr", err, 0);

        step(mk(1, 31, 32'hDEAD, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        check("err set", err, 1);
        for (int i = 0; i < 10; i++) begin
            step(idle(31, 31, 0));
            check("err sticky", err, 1);
        end

        step(mk(1, 6, 32'h66, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        a_valid = 0;
        #2;
        rst = 1;
        #1;
        sb.delete();
        check("async rst wr", wr, 0);
        check("async rst busy", busy, 0);
        check("async rst err", err, 0);
        check("async rst wr_addr", wr_addr, 0);
        #1;
        rst = 0;
        step(mk(1, 10, 32'hAA, 1, 11, 32'hBB, 0, 0, 0, 0, 1, 0, 0));
        step(mk(1, 10, 32'hAA, 1, 11, 32'hBB, 0, 0, 0, 0, 0, 1, 0));
        step(idle(10, 11, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
